program_sequencer: RTL and testbench
====================================

# program_sequencer

Program sequencer and instruction decoder for the 4-bit computational unit.
- Fetches 8-bit instructions from an asynchronous-read program memory and latches them into an instruction register.
- Decodes each instruction into the unit's mux selects and register enables.
- Resolves conditional jumps on the unit's `r_eq_0` flag.
- Sits between program memory and the computational unit; it is the only driver of the unit's control inputs.

## Interface
Parameters: none (widths are fixed by the computational unit).

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge
- `sync_reset`  in  1  synchronous, active-high reset
- `pm_data`  in  8  program memory word at `pm_addr`, valid in the same cycle
- `r_eq_0`  in  1  registered zero flag from the computational unit
- `pm_addr`  out  8  program counter value
- `ir_nibble`  out  4  immediate / ALU function nibble to the unit
- `source_sel`  out  4  data bus source select
- `x_sel`, `y_sel`, `i_sel`  out  1 each  ALU operand selects and i-register input select
- `reg_en`  out  9  register enables: 0 x0, 1 x1, 2 y0, 3 y1, 4 r, 5 m, 6 i, 7 unused (always 0), 8 o_reg
- `dm_we`  out  1  data memory write strobe; the address is the unit's `i`
- `halted`  out  1  sequencer is stopped

## Operation
- State: `pc[7:0]`, `ir[7:0]`, `state` ∈ {S_RUN, S_HALT}.
- Control outputs are decoded combinationally from `ir`. Any field not set by an instruction is 0.
- Instruction encodings:
  - LOAD `0ddd nnnn`: `source_sel`=8, `ir_nibble`=nnnn, enable for destination ddd.
  - MOV `10dd dsss`: `source_sel`={0,sss}. Special case: sss=4 with ddd=4 selects `i_pins` (`source_sel`=9).
  - ALU `110x yfff`: `x_sel`=x, `y_sel`=y, `ir_nibble`={0,fff}, `reg_en[4]`=1, `source_sel`=0.
  - JUMP `111c c000`–`111c c111` with cc ∈ {00 JMP, 01 JZ, 10 JNZ}. The next program word is the absolute target address.
  - `1111 1000` is NOP; `1111 1100` is HALT. Other `11111xxx` codes decode as NOP.
- Destination codes ddd:
  - 0 x0, 1 x1, 2 y0, 3 y1, 4 o_reg (`reg_en[8]`), 5 m, 6 i (`i_sel`=0).
  - 7 is a data memory write: `dm_we`=1, plus i post-increment (`reg_en[6]`=1, `i_sel`=1).
- Source codes sss: 0 x0 … 7 dm, directly as `source_sel`.
- S_RUN, non-jump, non-halt: `ir` <= `pm_data`; `pc` <= `pc`+1.
- S_RUN, JUMP in `ir`: `pm_data` is the target word.
  - Taken = JMP, or JZ && `r_eq_0`, or JNZ && !`r_eq_0`.
  - `pc` <= taken ? `pm_data` : `pc`+1 (skips the address word).
  - `ir` <= NOP in both cases.
  - A JUMP asserts no enables and no `dm_we`.
- S_RUN, HALT in `ir`: state <= S_HALT.
- S_HALT: `pc` and `ir` hold, all enables and `dm_we` are 0, `halted`=1. Only `sync_reset` exits.
- `pc` arithmetic is modulo 256: 0xFF+1 = 0x00. A jump opcode at 0xFF takes its target from 0x00.

## Timing
- Reset, on the edge with `sync_reset`=1: `pc`=0, `ir`=NOP, state=S_RUN, `halted`=0.
- While `sync_reset`=1, outputs are forced to `reg_en`=9'h010, all other controls 0. This lets the unit clear `r` to 0 and `r_eq_0` to 1.
- Reset mid-jump or in halt takes priority over everything.
- First instruction from address 0 executes in the second cycle after reset deasserts.
- Per-instruction cost:
  - 1 cycle for LOAD, MOV, ALU and NOP.
  - JUMP costs 2 cycles (jump plus NOP bubble) before the next useful instruction, taken or not.
- `r_eq_0` is sampled in the JUMP's own cycle. An ALU instruction immediately before a JZ/JNZ is therefore seen.

## Structure
- Shared package `cu_pkg`:
  - opcode field positions
  - `NOP`/`HALT` encodings
  - jump condition codes
  - destination and source code constants
  - `reg_en` bit indices
  - `SRC_PM`=8, `SRC_IPINS`=9
- Sub-module `instruction_decoder`, purely combinational: `ir` in, all control outputs plus `is_jump`, `jump_cc` and `is_halt` out.
- The top level holds `pc`, `ir`, the state machine and the reset override.

## Test plan
- Reset then LOAD x0 ← 5 (0x05) at address 0 → `reg_en`=001, `source_sel`=8, `ir_nibble`=5 in cycle 2; `pm_addr` sequence 0, 1, 2.
- MOV dm ← x1 (0xB9) → `dm_we`=1, `source_sel`=1, `reg_en[6]`=1, `i_sel`=1. MOV o_reg ← i_pins (0xA4) → `source_sel`=9, `reg_en[8]`=1.
- ALU x1−y0 (0xD1), then JZ (0xE8) at 0x10 with target 0x40 at 0x11:
  - `r_eq_0`=1 → `pm_addr` 0x40 after the bubble.
  - `r_eq_0`=0 → `pm_addr` 0x12.
- JMP opcode at 0xFF, target 0x33 at 0x00 → fetch resumes at 0x33. `pc` wraps 0xFF→0x00 on straight-line code.
- HALT (0xFC) → `halted`=1, `pm_addr` frozen, `reg_en`=0 for 10 cycles; `sync_reset` pulse → `pc`=0, `halted`=0.
- `sync_reset` asserted in the jump cycle → `reg_en`=0x010, next `pm_addr`=0, no `dm_we`.

Source files
------------

// File: rtl/cu_pkg.sv
// ---------------------------------------------------------------------------
// cu_pkg
// Shared definitions for the 4-bit computational unit and its program
// sequencer: instruction field positions, special encodings, jump condition
// codes, destination/source codes, reg_en bit indices and the sequencer
// state type.  Also provides dest_ctrl(), which maps a 3-bit destination
// code onto the register enables, i-register select and data memory strobe.
// No ports (package).
// ---------------------------------------------------------------------------
package cu_pkg;

    // Sequencer state
    typedef enum logic {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } seq_state_t;

    // Jump condition field (ir[4:3] of a 111x_xxxx word)
    typedef enum logic [1:0] {
        CC_JMP  = 2'b00,
        CC_JZ   = 2'b01,
        CC_JNZ  = 2'b10,
        CC_MISC = 2'b11   // NOP / HALT group, not a jump
    } jump_cc_t;

    // Special encodings
    localparam logic [7:0] NOP  = 8'hF8;
    localparam logic [7:0] HALT = 8'hFC;

    // Opcode discrimination bits: 0xxx LOAD, 10xx MOV, 110x ALU, 111x JUMP/misc
    localparam int OPC_LOAD_BIT = 7;
    localparam int OPC_MOV_BIT  = 6;
    localparam int OPC_ALU_BIT  = 5;

    // Field positions (LSB of each field)
    localparam int LOAD_DST_LSB = 4;
    localparam int LOAD_NIB_LSB = 0;
    localparam int MOV_DST_LSB  = 3;
    localparam int MOV_SRC_LSB  = 0;
    localparam int ALU_X_BIT    = 4;
    localparam int ALU_Y_BIT    = 3;
    localparam int ALU_FN_LSB   = 0;
    localparam int JMP_CC_LSB   = 3;

    // Destination codes
    localparam logic [2:0] DST_X0    = 3'd0;
    localparam logic [2:0] DST_X1    = 3'd1;
    localparam logic [2:0] DST_Y0    = 3'd2;
    localparam logic [2:0] DST_Y1    = 3'd3;
    localparam logic [2:0] DST_O_REG = 3'd4;
    localparam logic [2:0] DST_M     = 3'd5;
    localparam logic [2:0] DST_I     = 3'd6;
    localparam logic [2:0] DST_DM    = 3'd7;

    // Source codes (used directly as source_sel for MOV)
    localparam logic [2:0] SRC_X0 = 3'd0;
    localparam logic [2:0] SRC_X1 = 3'd1;
    localparam logic [2:0] SRC_Y0 = 3'd2;
    localparam logic [2:0] SRC_Y1 = 3'd3;
    localparam logic [2:0] SRC_R  = 3'd4;
    localparam logic [2:0] SRC_M  = 3'd5;
    localparam logic [2:0] SRC_I  = 3'd6;
    localparam logic [2:0] SRC_DM = 3'd7;

    // Extended source selects that only the decoder produces
    localparam logic [3:0] SRC_PM    = 4'd8;
    localparam logic [3:0] SRC_IPINS = 4'd9;

    // reg_en bit indices (bit 7 is unused and always 0)
    localparam int EN_X0    = 0;
    localparam int EN_X1    = 1;
    localparam int EN_Y0    = 2;
    localparam int EN_Y1    = 3;
    localparam int EN_R     = 4;
    localparam int EN_M     = 5;
    localparam int EN_I     = 6;
    localparam int EN_O_REG = 8;

    // While reset is held only r is enabled so the unit clears r and r_eq_0
    localparam logic [8:0] RESET_REG_EN = 9'h010;

    typedef struct packed {
        logic [8:0] reg_en;
        logic       i_sel;
        logic       dm_we;
    } dest_ctrl_t;

    // A data memory write also post-increments i, so DST_DM enables i with
    // i_sel pointing at the incrementer rather than the data bus.
    function automatic dest_ctrl_t dest_ctrl(input logic [2:0] dst);
        dest_ctrl_t c;
        c = '0;
        case (dst)
            DST_X0:    c.reg_en[EN_X0]    = 1'b1;
            DST_X1:    c.reg_en[EN_X1]    = 1'b1;
            DST_Y0:    c.reg_en[EN_Y0]    = 1'b1;
            DST_Y1:    c.reg_en[EN_Y1]    = 1'b1;
            DST_O_REG: c.reg_en[EN_O_REG] = 1'b1;
            DST_M:     c.reg_en[EN_M]     = 1'b1;
            DST_I:     c.reg_en[EN_I]     = 1'b1;
            DST_DM: begin
                c.reg_en[EN_I] = 1'b1;
                c.i_sel        = 1'b1;
                c.dm_we        = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/instruction_decoder.sv
// ---------------------------------------------------------------------------
// instruction_decoder
// Purely combinational decode of the 8-bit instruction register into the
// computational unit's control signals, plus jump/halt flags for the
// sequencer.
// Ports:
//   ir          in  8  instruction register
//   ir_nibble   out 4  immediate / ALU function nibble
//   source_sel  out 4  data bus source select
//   x_sel       out 1  ALU x operand select
//   y_sel       out 1  ALU y operand select
//   i_sel       out 1  i-register input select (1 = post-increment)
//   reg_en      out 9  register enables
//   dm_we       out 1  data memory write strobe
//   is_jump     out 1  ir holds a JMP/JZ/JNZ opcode
//   jump_cc     out 2  jump condition field
//   is_halt     out 1  ir holds HALT
// ---------------------------------------------------------------------------
module instruction_decoder
    import cu_pkg::*;
(
    input  logic [7:0] ir,
    output logic [3:0] ir_nibble,
    output logic [3:0] source_sel,
    output logic       x_sel,
    output logic       y_sel,
    output logic       i_sel,
    output logic [8:0] reg_en,
    output logic       dm_we,
    output logic       is_jump,
    output jump_cc_t   jump_cc,
    output logic       is_halt
);

    dest_ctrl_t dst;

    // Opcode classes are distinguished by the position of the first zero
    // in the top three bits; everything not set by a class stays 0.
    always_comb begin
        ir_nibble  = '0;
        source_sel = '0;
        x_sel      = 1'b0;
        y_sel      = 1'b0;
        i_sel      = 1'b0;
        reg_en     = '0;
        dm_we      = 1'b0;
        is_jump    = 1'b0;
        is_halt    = 1'b0;
        dst        = '0;
        jump_cc    = jump_cc_t'(ir[JMP_CC_LSB +: 2]);

        if (!ir[OPC_LOAD_BIT]) begin
            dst        = dest_ctrl(ir[LOAD_DST_LSB +: 3]);
            source_sel = SRC_PM;
            ir_nibble  = ir[LOAD_NIB_LSB +: 4];
            reg_en     = dst.reg_en;
            i_sel      = dst.i_sel;
            dm_we      = dst.dm_we;
        end else if (!ir[OPC_MOV_BIT]) begin
            dst = dest_ctrl(ir[MOV_DST_LSB +: 3]);
            // Moving r into o_reg is repurposed as "o_reg <- i_pins"
            if (ir[MOV_DST_LSB +: 3] == DST_O_REG && ir[MOV_SRC_LSB +: 3] == SRC_R)
                source_sel = SRC_IPINS;
            else
                source_sel = {1'b0, ir[MOV_SRC_LSB +: 3]};
            reg_en = dst.reg_en;
            i_sel  = dst.i_sel;
            dm_we  = dst.dm_we;
        end else if (!ir[OPC_ALU_BIT]) begin
            x_sel        = ir[ALU_X_BIT];
            y_sel        = ir[ALU_Y_BIT];
            ir_nibble    = {1'b0, ir[ALU_FN_LSB +: 3]};
            reg_en[EN_R] = 1'b1;
        end else if (jump_cc != CC_MISC) begin
            is_jump = 1'b1;
        end else begin
            // Remaining 11111xxx codes are NOP except the HALT word
            is_halt = (ir == HALT);
        end
    end

endmodule

// File: rtl/program_sequencer.sv
// ---------------------------------------------------------------------------
// program_sequencer
// Fetches instructions from asynchronous-read program memory, holds the
// program counter and instruction register, resolves conditional jumps on
// r_eq_0 and drives all control inputs of the computational unit.
// Ports:
//   clk         in  1  system clock
//   sync_reset  in  1  synchronous active-high reset
//   pm_data     in  8  program memory word at pm_addr
//   r_eq_0      in  1  zero flag from the computational unit
//   pm_addr     out 8  program counter
//   ir_nibble   out 4  immediate / ALU function nibble
//   source_sel  out 4  data bus source select
//   x_sel       out 1  ALU x operand select
//   y_sel       out 1  ALU y operand select
//   i_sel       out 1  i-register input select
//   reg_en      out 9  register enables
//   dm_we       out 1  data memory write strobe
//   halted      out 1  sequencer stopped on HALT
// ---------------------------------------------------------------------------
module program_sequencer
    import cu_pkg::*;
(
    input  logic       clk,
    input  logic       sync_reset,
    input  logic [7:0] pm_data,
    input  logic       r_eq_0,
    output logic [7:0] pm_addr,
    output logic [3:0] ir_nibble,
    output logic [3:0] source_sel,
    output logic       x_sel,
    output logic       y_sel,
    output logic       i_sel,
    output logic [8:0] reg_en,
    output logic       dm_we,
    output logic       halted
);

    logic [7:0] pc, pc_next;
    logic [7:0] ir, ir_next;
    seq_state_t state, state_next;

    logic [3:0] dec_ir_nibble;
    logic [3:0] dec_source_sel;
    logic       dec_x_sel;
    logic       dec_y_sel;
    logic       dec_i_sel;
    logic [8:0] dec_reg_en;
    logic       dec_dm_we;
    logic       dec_is_jump;
    jump_cc_t   dec_jump_cc;
    logic       dec_is_halt;
    logic       taken;

    instruction_decoder u_decoder (
        .ir         (ir),
        .ir_nibble  (dec_ir_nibble),
        .source_sel (dec_source_sel),
        .x_sel      (dec_x_sel),
        .y_sel      (dec_y_sel),
        .i_sel      (dec_i_sel),
        .reg_en     (dec_reg_en),
        .dm_we      (dec_dm_we),
        .is_jump    (dec_is_jump),
        .jump_cc    (dec_jump_cc),
        .is_halt    (dec_is_halt)
    );

    // State register: pc, ir and the run/halt state.  Reset wins over any
    // pending jump or halt.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            pc    <= 8'h00;
            ir    <= NOP;
            state <= S_RUN;
        end else begin
            pc    <= pc_next;
            ir    <= ir_next;
            state <= state_next;
        end
    end

    // r_eq_0 is used in the jump's own cycle, so an ALU result computed by
    // the instruction just before the jump is already visible here.
    always_comb begin
        case (dec_jump_cc)
            CC_JMP:  taken = 1'b1;
            CC_JZ:   taken = r_eq_0;
            CC_JNZ:  taken = !r_eq_0;
            default: taken = 1'b0;
        endcase
    end

    // Next-state logic.  During a jump pm_data is the address word; the
    // NOP loaded into ir is the bubble that covers the refetch.
    always_comb begin
        pc_next    = pc;
        ir_next    = ir;
        state_next = state;
        case (state)
            S_RUN: begin
                if (dec_is_halt) begin
                    state_next = S_HALT;
                end else if (dec_is_jump) begin
                    pc_next = taken ? pm_data : pc + 8'd1;
                    ir_next = NOP;
                end else begin
                    pc_next = pc + 8'd1;
                    ir_next = pm_data;
                end
            end
            S_HALT: begin
                pc_next    = pc;
                ir_next    = ir;
                state_next = S_HALT;
            end
            default: state_next = S_RUN;
        endcase
    end

    // Output logic: reset forces only r enabled; halt silences everything.
    always_comb begin
        pm_addr    = pc;
        halted     = (state == S_HALT);
        ir_nibble  = dec_ir_nibble;
        source_sel = dec_source_sel;
        x_sel      = dec_x_sel;
        y_sel      = dec_y_sel;
        i_sel      = dec_i_sel;
        reg_en     = dec_reg_en;
        dm_we      = dec_dm_we;
        if (sync_reset || state == S_HALT) begin
            ir_nibble  = '0;
            source_sel = '0;
            x_sel      = 1'b0;
            y_sel      = 1'b0;
            i_sel      = 1'b0;
            reg_en     = sync_reset ? RESET_REG_EN : 9'h000;
            dm_we      = 1'b0;
        end
    end

endmodule

// File: tb/tb_program_sequencer.sv
// ---------------------------------------------------------------------------
// tb_program_sequencer
// Self-checking bench for program_sequencer.  A program memory array feeds
// pm_data; directed scenarios cover reset, MOV decode, conditional jumps,
// pc wrap and halt, and a randomized run is checked against an
// instruction-level reference model.
// ---------------------------------------------------------------------------
module tb_program_sequencer;

    logic       clk;
    logic       sync_reset;
    logic [7:0] pm_data;
    logic       r_eq_0;
    logic [7:0] pm_addr;
    logic [3:0] ir_nibble;
    logic [3:0] source_sel;
    logic       x_sel;
    logic       y_sel;
    logic       i_sel;
    logic [8:0] reg_en;
    logic       dm_we;
    logic       halted;

    logic [7:0] mem [0:255];
    int checks;
    int errors;

    program_sequencer dut (
        .clk        (clk),
        .sync_reset (sync_reset),
        .pm_data    (pm_data),
        .r_eq_0     (r_eq_0),
        .pm_addr    (pm_addr),
        .ir_nibble  (ir_nibble),
        .source_sel (source_sel),
        .x_sel      (x_sel),
        .y_sel      (y_sel),
        .i_sel      (i_sel),
        .reg_en     (reg_en),
        .dm_we      (dm_we),
        .halted     (halted)
    );

    assign pm_data = mem[pm_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control word packing: nibble, source, x, y, i, reg_en, dm_we
    function automatic logic [20:0] mk(input int nib, input int src, input logic x,
                                       input logic y, input logic i,
                                       input logic [8:0] en, input logic we);
        return {nib[3:0], src[3:0], x, y, i, en, we};
    endfunction

    function automatic logic [20:0] ctrl_now();
        return {ir_nibble, source_sel, x_sel, y_sel, i_sel, reg_en, dm_we};
    endfunction

    // Reference decode written from the instruction table
    function automatic logic [20:0] ref_ctrl(input logic [7:0] w);
        int wi, d, s;
        logic [8:0] en;
        logic isel, we;
        wi = int'(w);
        if (wi < 128) d = (wi / 16) % 8;
        else          d = (wi / 8) % 8;
        isel = 1'b0;
        we   = 1'b0;
        if (d < 4)       en = 9'(1 << d);
        else if (d == 4) en = 9'h100;
        else if (d == 7) begin en = 9'h040; isel = 1'b1; we = 1'b1; end
        else             en = 9'(1 << d);
        if (wi < 128) return mk(wi % 16, 8, 1'b0, 1'b0, isel, en, we);
        if (wi < 192) begin
            s = wi % 8;
            return mk(0, (s == 4 && d == 4) ? 9 : s, 1'b0, 1'b0, isel, en, we);
        end
        if (wi < 224) return mk(wi % 8, 0, w[4], w[3], 1'b0, 9'h010, 1'b0);
        return '0;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic clear_mem();
        for (int a = 0; a < 256; a++) mem[a] = 8'hF8;
    endtask

    task automatic do_reset();
        sync_reset = 1'b1;
        #1;
        next_cycle();
        sync_reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        clear_mem();
        mem[0] = 8'h05;
        sync_reset = 1'b1;
        r_eq_0 = 1'b0;
        #1;
        checks++;
        if (ctrl_now() !== mk(0, 0, 0, 0, 0, 9'h010, 0)) begin
            errors++;
            $display("[TB] FAIL reset_override: got %h want %h", ctrl_now(), mk(0, 0, 0, 0, 0, 9'h010, 0));
        end
        next_cycle();
        sync_reset = 1'b0;
        #1;
        checks++;
        if (pm_addr !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_pc: got %h want 00", pm_addr);
        end
        checks++;
        if (ctrl_now() !== 21'h0 || halted !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_nop: got %h halted %b want 0 halted 0", ctrl_now(), halted);
        end
        next_cycle();
        checks++;
        if (pm_addr !== 8'h01 || ctrl_now() !== mk(5, 8, 0, 0, 0, 9'h001, 0)) begin
            errors++;
            $display("[TB] FAIL load_x0: got pc %h ctrl %h want pc 01 ctrl %h", pm_addr, ctrl_now(), mk(5, 8, 0, 0, 0, 9'h001, 0));
        end
        next_cycle();
        checks++;
        if (pm_addr !== 8'h02) begin
            errors++;
            $display("[TB] FAIL pc_seq: got %h want 02", pm_addr);
        end
    endtask

    task automatic test_mov();
        clear_mem();
        mem[0] = 8'hB9;
        mem[1] = 8'hA4;
        do_reset();
        next_cycle();
        checks++;
        if (ctrl_now() !== mk(0, 1, 0, 0, 1, 9'h040, 1)) begin
            errors++;
            $display("[TB] FAIL mov_dm_x1: got %h want %h", ctrl_now(), mk(0, 1, 0, 0, 1, 9'h040, 1));
        end
        next_cycle();
        checks++;
        if (ctrl_now() !== mk(0, 9, 0, 0, 0, 9'h100, 0)) begin
            errors++;
            $display("[TB] FAIL mov_oreg_ipins: got %h want %h", ctrl_now(), mk(0, 9, 0, 0, 0, 9'h100, 0));
        end
    endtask

    task automatic test_jz(input logic r);
        logic [7:0] tgt;
        logic [20:0] want;
        clear_mem();
        mem[8'h00] = 8'hE0;
        mem[8'h01] = 8'h0F;
        mem[8'h0F] = 8'hD1;
        mem[8'h10] = 8'hE8;
        mem[8'h11] = 8'h40;
        mem[8'h12] = 8'h17;
        mem[8'h40] = 8'h05;
        tgt  = r ? 8'h40 : 8'h12;
        want = r ? mk(5, 8, 0, 0, 0, 9'h001, 0) : mk(7, 8, 0, 0, 0, 9'h002, 0);
        r_eq_0 = r;
        do_reset();
        next_cycle();
        next_cycle();
        next_cycle();
        checks++;
        if (pm_addr !== 8'h10 || ctrl_now() !== mk(1, 0, 1, 0, 0, 9'h010, 0)) begin
            errors++;
            $display("[TB] FAIL alu_before_jz: got pc %h ctrl %h want pc 10 ctrl %h", pm_addr, ctrl_now(), mk(1, 0, 1, 0, 0, 9'h010, 0));
        end
        next_cycle();
        checks++;
        if (pm_addr !== 8'h11 || ctrl_now() !== 21'h0) begin
            errors++;
            $display("[TB] FAIL jz_cycle r=%0b: got pc %h ctrl %h want pc 11 ctrl 0", r, pm_addr, ctrl_now());
        end
        next_cycle();
        checks++;
        if (pm_addr !== tgt || ctrl_now() !== 21'h0) begin
            errors++;
            $display("[TB] FAIL jz_bubble r=%0b: got pc %h ctrl %h want pc %h ctrl 0", r, pm_addr, ctrl_now(), tgt);
        end
        next_cycle();
        checks++;
        if (pm_addr !== tgt + 8'd1 || ctrl_now() !== want) begin
            errors++;
            $display("[TB] FAIL jz_resume r=%0b: got pc %h ctrl %h want pc %h ctrl %h", r, pm_addr, ctrl_now(), tgt + 8'd1, want);
        end
    endtask

    task automatic test_wrap();
        clear_mem();
        mem[8'h00] = 8'h33;
        mem[8'h01] = 8'hE0;
        mem[8'h02] = 8'hFE;
        mem[8'hFF] = 8'hE0;
        mem[8'h33] = 8'h21;
        r_eq_0 = 1'b0;
        do_reset();
        next_cycle();
        checks++;
        if (ctrl_now() !== mk(3, 8, 0, 0, 0, 9'h008, 0)) begin
            errors++;
            $display("[TB] FAIL load_y1: got %h want %h", ctrl_now(), mk(3, 8, 0, 0, 0, 9'h008, 0));
        end
        next_cycle();
        next_cycle();
        next_cycle();
        checks++;
        if (pm_addr !== 8'hFF) begin
            errors++;
            $display("[TB] FAIL pc_ff: got %h want ff", pm_addr);
        end
        next_cycle();
        checks++;
        if (pm_addr !== 8'h00) begin
            errors++;
            $display("[TB] FAIL pc_wrap: got %h want 00", pm_addr);
        end
        next_cycle();
        checks++;
        if (pm_addr !== 8'h33) begin
            errors++;
            $display("[TB] FAIL jmp_at_ff: got %h want 33", pm_addr);
        end
        next_cycle();
        checks++;
        if (pm_addr !== 8'h34 || ctrl_now() !== mk(1, 8, 0, 0, 0, 9'h004, 0)) begin
            errors++;
            $display("[TB] FAIL after_wrap_jmp: got pc %h ctrl %h want pc 34 ctrl %h", pm_addr, ctrl_now(), mk(1, 8, 0, 0, 0, 9'h004, 0));
        end
    endtask

    task automatic test_halt();
        clear_mem();
        mem[0] = 8'hFC;
        do_reset();
        next_cycle();
        checks++;
        if (halted !== 1'b0 || pm_addr !== 8'h01) begin
            errors++;
            $display("[TB] FAIL halt_decode: got halted %b pc %h want 0 01", halted, pm_addr);
        end
        for (int k = 0; k < 10; k++) begin
            next_cycle();
            checks++;
            if (halted !== 1'b1 || pm_addr !== 8'h01 || reg_en !== 9'h000 || dm_we !== 1'b0) begin
                errors++;
                $display("[TB] FAIL halt_hold %0d: got halted %b pc %h en %h we %b want 1 01 000 0", k, halted, pm_addr, reg_en, dm_we);
            end
        end
        sync_reset = 1'b1;
        #1;
        checks++;
        if (reg_en !== 9'h010) begin
            errors++;
            $display("[TB] FAIL halt_reset_en: got %h want 010", reg_en);
        end
        next_cycle();
        sync_reset = 1'b0;
        #1;
        checks++;
        if (pm_addr !== 8'h00 || halted !== 1'b0) begin
            errors++;
            $display("[TB] FAIL halt_exit: got pc %h halted %b want 00 0", pm_addr, halted);
        end
    endtask

    task automatic test_reset_in_jump();
        clear_mem();
        mem[8'h00] = 8'hE0;
        mem[8'h01] = 8'h80;
        mem[8'h80] = 8'hB9;
        do_reset();
        next_cycle();
        sync_reset = 1'b1;
        #1;
        checks++;
        if (reg_en !== 9'h010 || dm_we !== 1'b0) begin
            errors++;
            $display("[TB] FAIL jump_reset_ctrl: got en %h we %b want 010 0", reg_en, dm_we);
        end
        next_cycle();
        sync_reset = 1'b0;
        #1;
        checks++;
        if (pm_addr !== 8'h00 || ctrl_now() !== 21'h0) begin
            errors++;
            $display("[TB] FAIL jump_reset_pc: got pc %h ctrl %h want 00 0", pm_addr, ctrl_now());
        end
        next_cycle();
        checks++;
        if (pm_addr !== 8'h01) begin
            errors++;
            $display("[TB] FAIL jump_reset_refetch: got %h want 01", pm_addr);
        end
    endtask

    // Random program with random r_eq_0 and occasional resets, checked
    // instruction by instruction against an interpreter of the ISA.
    task automatic test_random();
        logic [7:0] exp_pc;
        logic [7:0] exp_ir;
        logic       exp_halted;
        logic       rst, r;
        logic [20:0] want;
        int cc;
        for (int a = 0; a < 256; a++) mem[a] = 8'($urandom_range(255));
        do_reset();
        exp_pc = 8'h00;
        exp_ir = 8'hF8;
        exp_halted = 1'b0;
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(31) == 0);
            r   = 1'($urandom_range(1));
            sync_reset = rst;
            r_eq_0 = r;
            #1;
            if (rst)             want = mk(0, 0, 0, 0, 0, 9'h010, 0);
            else if (exp_halted) want = '0;
            else                 want = ref_ctrl(exp_ir);
            checks++;
            if (ctrl_now() !== want || pm_addr !== exp_pc) begin
                errors++;
                $display("[TB] FAIL random cyc %0d ir %h: got pc %h ctrl %h want pc %h ctrl %h", n, exp_ir, pm_addr, ctrl_now(), exp_pc, want);
            end
            if (!rst) begin
                checks++;
                if (halted !== exp_halted) begin
                    errors++;
                    $display("[TB] FAIL random_halted cyc %0d: got %b want %b", n, halted, exp_halted);
                end
            end
            if (rst) begin
                exp_pc = 8'h00;
                exp_ir = 8'hF8;
                exp_halted = 1'b0;
            end else if (exp_halted) begin
                exp_halted = 1'b1;
            end else if (exp_ir == 8'hFC) begin
                exp_halted = 1'b1;
            end else if (exp_ir >= 8'hE0 && exp_ir < 8'hF8) begin
                cc = (int'(exp_ir) / 8) % 4;
                if (cc == 0 || (cc == 1 && r) || (cc == 2 && !r))
                    exp_pc = mem[exp_pc];
                else
                    exp_pc = 8'((int'(exp_pc) + 1) % 256);
                exp_ir = 8'hF8;
            end else begin
                exp_ir = mem[exp_pc];
                exp_pc = 8'((int'(exp_pc) + 1) % 256);
            end
            next_cycle();
        end
        sync_reset = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        sync_reset = 1'b1;
        r_eq_0 = 1'b0;
        clear_mem();
        $display("[TB] starting program_sequencer bench");
        test_reset();
        test_mov();
        test_jz(1'b1);
        test_jz(1'b0);
        test_wrap();
        test_halt();
        test_reset_in_jump();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
